// File: rtl/hex_scan_mux.sv
// hex_scan_mux
//   Multi-channel hex display scanner. It captures NUM_CH result words into shadow registers
//   whenever io_din_valid is high. At each frame boundary it freezes one word (frame_word) so
//   that the digits shown never tear mid-frame. It then scans that word one nibble at a time
//   onto the board digit mux. The channel shown either rotates automatically, advancing every
//   DWELL frames, or follows the operator's ch_sel.
//
// Optional feature: define HEX_SCAN_BLANK_EN to enable leading-zero blanking on BLANK.
// Without it, BLANK is tied low.
//
// Ports
//   clock        in  system clock, posedge
//   reset        in  synchronous active-high reset
//   io_din       in  NUM_CH packed words, channel c at [c*DATA_W +: DATA_W]
//   io_din_valid in  capture io_din into the shadow registers
//   mode_auto    in  1 = rotate channels, 0 = show ch_sel
//   ch_sel       in  manual channel select (clamped to NUM_CH-1)
//   AN           out digit index, 0 = least significant nibble
//   D            out nibble for digit AN
//   CH           out channel of the current frame
//   BLANK        out digit must be dark (leading-zero blanking)
//   digit_strobe out one-cycle pulse when AN/D first show a new digit
module hex_scan_mux #(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned SCAN_DIV = 1,
   parameter int unsigned DWELL    = 1,
   localparam int unsigned DIGITS  = DATA_W / 4,
   localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned AN_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_CH*DATA_W-1:0]   io_din,
   input  logic                       io_din_valid,
   input  logic                       mode_auto,
   input  logic [CH_W-1:0]            ch_sel,
   output logic [AN_W-1:0]            AN,
   output logic [3:0]                 D,
   output logic [CH_W-1:0]            CH,
   output logic                       BLANK,
   output logic                       digit_strobe
);

   localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DWL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

   // State
   logic [DATA_W-1:0] r_shadow [NUM_CH];
   logic [DATA_W-1:0] r_frame_word;
   logic [CNT_W-1:0]  r_cnt;
   logic [AN_W-1:0]   r_dig;
   logic [DWL_W-1:0]  r_dwell;
   logic [CH_W-1:0]   r_ch;
   // Set by reset. Marks the all-zero frame shown right after reset, which does not count
   // toward dwell.
   logic              r_first;
   logic              r_tick_q;
   logic [AN_W-1:0]   r_an;
   logic [3:0]        r_d;
   logic              r_strobe;

   // Next-state / combinational
   logic              w_tick;
   logic              w_frame_end;
   logic [CNT_W-1:0]  w_cnt_next;
   logic [AN_W-1:0]   w_dig_next;
   logic [CH_W-1:0]   w_next_ch;
   logic [DWL_W-1:0]  w_next_dwell;
   logic [3:0]        w_nibble;
   logic              w_blank;

   always_comb begin
      w_tick      = (r_cnt == CNT_W'(SCAN_DIV - 1));
      w_frame_end = w_tick && (r_dig == AN_W'(DIGITS - 1));

      w_cnt_next = w_tick ? '0 : r_cnt + CNT_W'(1);

      w_dig_next = r_dig;
      if (w_tick) begin
         w_dig_next = (r_dig == AN_W'(DIGITS - 1)) ? '0 : r_dig + AN_W'(1);
      end

      // Channel for the next frame. Only consumed at frame end, so mid-frame changes to
      // mode_auto/ch_sel take effect at the boundary only.
      w_next_ch    = r_ch;
      w_next_dwell = r_dwell;
      if (!mode_auto) begin
         w_next_dwell = '0;
         if (32'(ch_sel) >= NUM_CH) begin
            w_next_ch = CH_W'(NUM_CH - 1);
         end else begin
            w_next_ch = ch_sel;
         end
      end else if (r_first) begin
         // The reset frame is not counted; the next frame shows the current channel.
         w_next_ch    = r_ch;
         w_next_dwell = r_dwell;
      end else if (r_dwell == DWL_W'(DWELL - 1)) begin
         w_next_dwell = '0;
         w_next_ch    = (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + CH_W'(1);
      end else begin
         w_next_dwell = r_dwell + DWL_W'(1);
      end

      w_nibble = 4'(r_frame_word >> {r_dig, 2'b00});

`ifdef HEX_SCAN_BLANK_EN
      // Dark when this nibble and every nibble above it is zero. Digit 0 always shows.
      w_blank = (r_dig != '0) && ((r_frame_word >> {r_dig, 2'b00}) == '0);
`else
      w_blank = 1'b0;
`endif
   end

   // Shadow capture
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_shadow[c] <= '0;
         end
      end else if (io_din_valid) begin
         for (int c = 0; c < NUM_CH; c++) begin
            r_shadow[c] <= io_din[c*DATA_W +: DATA_W];
         end
      end
   end

   // Scan timing, frame freeze and channel selection
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt        <= '0;
         r_dig        <= '0;
         r_dwell      <= '0;
         r_ch         <= '0;
         r_first      <= 1'b1;
         r_frame_word <= '0;
         r_tick_q     <= 1'b0;
      end else begin
         r_cnt    <= w_cnt_next;
         r_dig    <= w_dig_next;
         r_tick_q <= w_tick;
         if (w_frame_end) begin
            // The shadow is read before this edge's capture, so a coincident io_din_valid
            // shows up one frame later.
            r_frame_word <= r_shadow[w_next_ch];
            r_ch         <= w_next_ch;
            r_dwell      <= w_next_dwell;
            r_first      <= 1'b0;
         end
      end
   end

   // Registered display outputs. r_tick_q marks the cycle r_dig took a new value, so the
   // strobe lands on the first cycle AN shows it.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_an     <= '0;
         r_d      <= '0;
         r_strobe <= 1'b0;
      end else begin
         r_an     <= r_dig;
         r_d      <= w_nibble;
         r_strobe <= r_tick_q;
      end
   end

`ifdef HEX_SCAN_BLANK_EN
   logic r_blank;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_blank <= 1'b0;
      end else begin
         r_blank <= w_blank;
      end
   end

   assign BLANK = r_blank;
`else
   logic w_blank_unused;

   assign w_blank_unused = w_blank;
   assign BLANK          = 1'b0;
`endif

   assign AN           = r_an;
   assign D            = r_d;
   assign CH           = r_ch;
   assign digit_strobe = r_strobe;

endmodule

// File: tb/tb_hex_scan_mux.sv
module tb_hex_scan_mux;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset;

   // Instances A (DWELL=1) and B (DWELL=2) share inputs.
   logic [127:0] din;
   logic         din_valid;
   logic         mode_auto;
   logic [1:0]   ch_sel;
   logic [2:0]   an_a, an_b;
   logic [3:0]   d_a, d_b;
   logic [1:0]   ch_a, ch_b;
   logic         blank_a, blank_b, stb_a, stb_b;

   // Instance C: NUM_CH=3, SCAN_DIV=3.
   logic [95:0]  din_c;
   logic         valid_c;
   logic         mode_c;
   logic [1:0]   sel_c;
   logic [2:0]   an_c;
   logic [3:0]   d_c;
   logic [1:0]   ch_c;
   logic         blank_c, stb_c;

   hex_scan_mux #(.NUM_CH(4), .DATA_W(32), .SCAN_DIV(1), .DWELL(1)) u_dut_a (
      .clock(clock), .reset(reset), .io_din(din), .io_din_valid(din_valid),
      .mode_auto(mode_auto), .ch_sel(ch_sel), .AN(an_a), .D(d_a), .CH(ch_a),
      .BLANK(blank_a), .digit_strobe(stb_a)
   );

   hex_scan_mux #(.NUM_CH(4), .DATA_W(32), .SCAN_DIV(1), .DWELL(2)) u_dut_b (
      .clock(clock), .reset(reset), .io_din(din), .io_din_valid(din_valid),
      .mode_auto(mode_auto), .ch_sel(ch_sel), .AN(an_b), .D(d_b), .CH(ch_b),
      .BLANK(blank_b), .digit_strobe(stb_b)
   );

   hex_scan_mux #(.NUM_CH(3), .DATA_W(32), .SCAN_DIV(3), .DWELL(1)) u_dut_c (
      .clock(clock), .reset(reset), .io_din(din_c), .io_din_valid(valid_c),
      .mode_auto(mode_c), .ch_sel(sel_c), .AN(an_c), .D(d_c), .CH(ch_c),
      .BLANK(blank_c), .digit_strobe(stb_c)
   );

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic [3:0] nib(input logic [31:0] w, input int j);
      return w[j*4 +: 4];
   endfunction

   function automatic logic exp_blank(input logic [31:0] w, input int j);
`ifdef HEX_SCAN_BLANK_EN
      return (j != 0) && ((w >> (4 * j)) == 32'h0);
`else
      return (w == 32'hFFFF_FFFF) && (j < 0);
`endif
   endfunction

   task automatic do_reset();
      reset     = 1'b1;
      din_valid = 1'b0;
      valid_c   = 1'b0;
      step_n(2);
      check("rst_an",    32'(an_a),    32'h0);
      check("rst_d",     32'(d_a),     32'h0);
      check("rst_ch",    32'(ch_a),    32'h0);
      check("rst_blank", 32'(blank_a), 32'h0);
      check("rst_stb",   32'(stb_a),   32'h0);
      check("rst_ch_c",  32'(ch_c),    32'h0);
      reset = 1'b0;
   endtask

   // One record per frame: channel and frozen word shown by A and by B.
   typedef struct {
      logic [1:0]  ch_a;
      logic [31:0] w_a;
      logic [1:0]  ch_b;
      logic [31:0] w_b;
   } frame_t;

   frame_t tbl [10];

   initial begin
      tbl[0] = '{2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};
      tbl[1] = '{2'd0, 32'h1234_5678, 2'd0, 32'h1234_5678};
      tbl[2] = '{2'd1, 32'h8765_4321, 2'd0, 32'h1234_5678};
      tbl[3] = '{2'd2, 32'h0000_0000, 2'd1, 32'h8765_4321};
      tbl[4] = '{2'd3, 32'hCAFE_BABE, 2'd1, 32'h8765_4321};
      tbl[5] = '{2'd0, 32'h1234_5678, 2'd2, 32'h0000_0000};
      tbl[6] = '{2'd1, 32'h8765_4321, 2'd2, 32'h0000_0000};
      tbl[7] = '{2'd2, 32'h0000_0000, 2'd3, 32'hCAFE_BABE};
      tbl[8] = '{2'd3, 32'hCAFE_BABE, 2'd3, 32'hCAFE_BABE};
      tbl[9] = '{2'd0, 32'h1234_5678, 2'd0, 32'h1234_5678};

      din       = {32'hCAFE_BABE, 32'h0, 32'h8765_4321, 32'h1234_5678};
      din_valid = 1'b0;
      mode_auto = 1'b1;
      ch_sel    = 2'd0;
      din_c     = '0;
      valid_c   = 1'b0;
      mode_c    = 1'b1;
      sel_c     = 2'd0;

      // Auto rotation, DWELL=1 vs DWELL=2; shadow loaded on edge 3.
      do_reset();
      for (int n = 0; n < 10; n++) begin
         for (int j = 0; j < 8; j++) begin
            din_valid = ((8 * n + 1 + j) == 3);
            step();
            check("scan_an_a",  32'(an_a),    32'(j));
            check("scan_d_a",   32'(d_a),     32'(nib(tbl[n].w_a, j)));
            check("scan_stb_a", 32'(stb_a),   32'((n != 0) || (j != 0)));
            check("scan_blk_a", 32'(blank_a), 32'(exp_blank(tbl[n].w_a, j)));
            check("scan_an_b",  32'(an_b),    32'(j));
            check("scan_d_b",   32'(d_b),     32'(nib(tbl[n].w_b, j)));
            if (j < 7) begin
               check("scan_ch_a", 32'(ch_a), 32'(tbl[n].ch_a));
               check("scan_ch_b", 32'(ch_b), 32'(tbl[n].ch_b));
            end
         end
      end
      din_valid = 1'b0;

      // Valid coincident with frame end, then manual select and auto resume.
      do_reset();
      mode_auto = 1'b0;
      ch_sel    = 2'd0;
      din       = {32'h0, 32'h0, 32'h0, 32'h1111_1111};
      step_n(2);
      din_valid = 1'b1;
      step();                                   // edge 3
      din_valid = 1'b0;
      step_n(12);                               // edges 4..15
      din       = {32'h4444_4444, 32'h3333_3333, 32'h5555_5555, 32'h2222_2222};
      din_valid = 1'b1;
      step();                                   // edge 16, frame end
      din_valid = 1'b0;
      check("man_ch0", 32'(ch_a), 32'h0);
      for (int j = 0; j < 8; j++) begin
         step();                                // edges 17..24
         check("coinc_old_word", 32'(d_a), 32'h1);
         check("coinc_an", 32'(an_a), 32'(j));
      end
      step();                                   // edge 25
      check("coinc_new_word", 32'(d_a), 32'h2);
      step_n(2);                                // edges 26,27
      ch_sel = 2'd2;
      step_n(4);                                // edges 28..31
      check("man_ch_hold", 32'(ch_a), 32'h0);
      check("man_d_hold",  32'(d_a),  32'h2);
      step();                                   // edge 32
      check("man_ch_new", 32'(ch_a), 32'h2);
      step();                                   // edge 33
      check("man_d_new",  32'(d_a),  32'h3);
      check("man_an0",    32'(an_a), 32'h0);
      mode_auto = 1'b1;
      step_n(6);                                // edges 34..39
      check("auto_ch_hold", 32'(ch_a), 32'h2);
      step();                                   // edge 40
      check("auto_resume_ch", 32'(ch_a), 32'h3);
      step();                                   // edge 41
      check("auto_resume_d", 32'(d_a), 32'h4);

      // Leading-zero blanking and reset mid-frame.
      do_reset();
      mode_auto = 1'b0;
      ch_sel    = 2'd0;
      din       = {96'h0, 32'h0000_0A30};
      step_n(2);
      din_valid = 1'b1;
      step();                                   // edge 3
      din_valid = 1'b0;
      step_n(5);                                // edges 4..8
      for (int j = 0; j < 8; j++) begin
         step();                                // edges 9..16
         check("blk_d",     32'(d_a),     32'(nib(32'h0000_0A30, j)));
         check("blk_blank", 32'(blank_a), 32'(exp_blank(32'h0000_0A30, j)));
      end
      step_n(3);
      check("mid_an_pre", 32'(an_a), 32'h2);
      reset = 1'b1;
      step();
      check("mid_rst_an",    32'(an_a),    32'h0);
      check("mid_rst_d",     32'(d_a),     32'h0);
      check("mid_rst_ch",    32'(ch_a),    32'h0);
      check("mid_rst_stb",   32'(stb_a),   32'h0);
      check("mid_rst_blank", 32'(blank_a), 32'h0);
      reset = 1'b0;
      step_n(8);
      for (int j = 0; j < 8; j++) begin
         step();
         check("shadow_lost_d", 32'(d_a),     32'h0);
         check("shadow_lost_b", 32'(blank_a), 32'(exp_blank(32'h0, j)));
      end

      // SCAN_DIV=3, 24-cycle frame, ch_sel clamp on NUM_CH=3.
      do_reset();
      mode_c = 1'b0;
      sel_c  = 2'd3;
      din_c  = {32'h9ABC_DEF0, 32'h0, 32'h0};
      for (int k = 1; k <= 50; k++) begin
         logic [31:0] w;
         int          e_an;
         valid_c = (k == 2);
         step();
         e_an = ((k - 1) / 3) % 8;
         w    = (k >= 25) ? 32'h9ABC_DEF0 : 32'h0;
         check("div_an",  32'(an_c),  32'(e_an));
         check("div_stb", 32'(stb_c), 32'((k % 3 == 1) && (k >= 4)));
         check("div_ch",  32'(ch_c),  (k >= 24) ? 32'h2 : 32'h0);
         check("div_d",   32'(d_c),   32'(nib(w, e_an)));
      end
      valid_c = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
